// File: rtl/l2d_rr_scheduler_if.sv
// Bundle of requester-side and converter-side handshake buses for l2d_rr_scheduler.
// master = scheduler, slave = the requesters plus the converter.
interface l2d_rr_scheduler_if #(
  parameter int N_REQ = 4
) ();
  // Every stb/ack pair: a word moves on a rising edge where both are high; the
  // sender holds stb and data until then, and each side drops its strobe after.
  logic [64*N_REQ-1:0] req_a;
  logic [N_REQ-1:0]    req_a_stb;
  logic [N_REQ-1:0]    req_a_ack;
  logic [63:0]         req_z;
  logic [N_REQ-1:0]    req_z_stb;
  logic [N_REQ-1:0]    req_z_ack;
  logic [63:0]         conv_a;
  logic                conv_a_stb;
  logic                conv_a_ack;
  logic [63:0]         conv_z;
  logic                conv_z_stb;
  logic                conv_z_ack;

  modport master (
    input  req_a, req_a_stb, req_z_ack, conv_a_ack, conv_z, conv_z_stb,
    output req_a_ack, req_z, req_z_stb, conv_a, conv_a_stb, conv_z_ack
  );

  modport slave (
    output req_a, req_a_stb, req_z_ack, conv_a_ack, conv_z, conv_z_stb,
    input  req_a_ack, req_z, req_z_stb, conv_a, conv_a_stb, conv_z_ack
  );
endinterface

// File: rtl/l2d_rr_scheduler.sv
// Round-robin scheduler sharing one long_to_double converter among N_REQ requesters,
// one conversion in flight; results return to the issuing requester.
module l2d_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  l2d_rr_scheduler_if.master bus,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic [31:0]        conv_count,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_ISSUE   = 3'd2,
    S_COLLECT = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] req_a_ack_q, req_a_ack_d;
  logic [N_REQ-1:0] req_z_stb_q, req_z_stb_d;
  logic             conv_a_stb_q, conv_a_stb_d;
  logic             conv_z_ack_q, conv_z_ack_d;
  logic             busy_q, busy_d;
  logic [31:0]      conv_count_q, conv_count_d;
  logic [63:0]      op_q, op_d;
  logic [63:0]      res_q, res_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W:0]   cand;
  logic [63:0]      op_sel;
  logic             a_xfer, ca_xfer, cz_xfer, z_xfer;

  // Scan from last+1 upward with wrap so the most recent winner is checked last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!pick_found && bus.req_a_stb[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        op_sel = bus.req_a[64*i +: 64];
      end
    end
  end

  assign a_xfer  = req_a_ack_q[grant_idx_q] & bus.req_a_stb[grant_idx_q];
  assign ca_xfer = conv_a_stb_q & bus.conv_a_ack;
  assign cz_xfer = conv_z_ack_q & bus.conv_z_stb;
  assign z_xfer  = req_z_stb_q[grant_idx_q] & bus.req_z_ack[grant_idx_q];

  // Each handshake output is registered: it rises one cycle into its state and
  // is cleared on the transfer edge together with the state change.
  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_d       = last_q;
    req_a_ack_d  = '0;
    req_z_stb_d  = '0;
    conv_a_stb_d = 1'b0;
    conv_z_ack_d = 1'b0;
    conv_count_d = conv_count_q;
    op_d         = op_q;
    res_d        = res_q;
    busy_d       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_idx_d = pick_idx;
          state_d     = S_GRANT;
        end
      end
      S_GRANT: begin
        // A requester that withdraws stb mid-grant is simply waited for.
        if (a_xfer) begin
          op_d    = op_sel;
          state_d = S_ISSUE;
        end else begin
          req_a_ack_d[grant_idx_q] = 1'b1;
        end
      end
      S_ISSUE: begin
        if (ca_xfer) begin
          state_d = S_COLLECT;
        end else begin
          conv_a_stb_d = 1'b1;
        end
      end
      S_COLLECT: begin
        if (cz_xfer) begin
          res_d   = bus.conv_z;
          state_d = S_DELIVER;
        end else begin
          conv_z_ack_d = 1'b1;
        end
      end
      S_DELIVER: begin
        if (z_xfer) begin
          last_d       = grant_idx_q;
          conv_count_d = conv_count_q + 32'd1;
          state_d      = S_IDLE;
        end else begin
          req_z_stb_d[grant_idx_q] = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_idx_q  <= '0;
      last_q       <= IDX_W'(N_REQ-1);
      req_a_ack_q  <= '0;
      req_z_stb_q  <= '0;
      conv_a_stb_q <= 1'b0;
      conv_z_ack_q <= 1'b0;
      busy_q       <= 1'b0;
      conv_count_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_q       <= last_d;
      req_a_ack_q  <= req_a_ack_d;
      req_z_stb_q  <= req_z_stb_d;
      conv_a_stb_q <= conv_a_stb_d;
      conv_z_ack_q <= conv_z_ack_d;
      busy_q       <= busy_d;
      conv_count_q <= conv_count_d;
    end
  end

  // Operand/result registers only matter while their strobe is up, so no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    res_q <= res_d;
  end

  assign bus.req_a_ack  = req_a_ack_q;
  assign bus.req_z_stb  = req_z_stb_q;
  assign bus.req_z      = res_q;
  assign bus.conv_a     = op_q;
  assign bus.conv_a_stb = conv_a_stb_q;
  assign bus.conv_z_ack = conv_z_ack_q;
  assign grant_idx      = grant_idx_q;
  assign busy           = busy_q;
  assign conv_count     = conv_count_q;
  assign state_dbg      = state_q;

endmodule

// File: doc/l2d_rr_scheduler.md
# l2d_rr_scheduler

Round-robin scheduler that shares one `long_to_double` converter among `N_REQ` requesters in the Gaussian-sampler datapath. It accepts signed 64-bit integers from requesters over stb/ack handshakes and serialises them into the single converter, one conversion in flight at a time. It returns each IEEE-754 double to the requester that issued it and counts completed conversions.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters.
- `IDX_W`, 2: requester index width; must equal clog2(`N_REQ`).

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_a` in 64·N_REQ: requester operands; requester i drives `[64*i+63:64*i]`.
- `req_a_stb` in N_REQ: operand valid, one bit per requester.
- `req_a_ack` out N_REQ: operand accept, one-hot or zero.
- `req_z` out 64: result bus shared by all requesters.
- `req_z_stb` out N_REQ: result valid, one-hot or zero.
- `req_z_ack` in N_REQ: result accept.
- `conv_a` out 64: operand to the converter.
- `conv_a_stb` out 1: operand valid to the converter.
- `conv_a_ack` in 1: converter operand accept.
- `conv_z` in 64: converter result.
- `conv_z_stb` in 1: converter result valid.
- `conv_z_ack` out 1: converter result accept.
- `grant_idx` out IDX_W: index of the current or last granted requester.
- `busy` out 1: high whenever the state is not IDLE.
- `conv_count` out 32: number of completed deliveries; wraps at 2^32.

## Operation

- **Handshake rule (every port):** a transfer occurs on a rising edge where stb and ack are both high.
  - All stb and ack outputs are registered.
  - The sender holds stb and data stable until the transfer.
  - The block drops its stb or ack in the cycle after the transfer.
- **State machine:** IDLE → GRANT → ISSUE → COLLECT → DELIVER → IDLE.
- **IDLE:**
  - If any `req_a_stb` bit is set, select the first set bit scanning from `last+1` upward, modulo N_REQ.
  - Register the winner in `grant_idx` and go to GRANT.
  - If no bit is set, stay in IDLE.
- **GRANT:**
  - Assert `req_a_ack[grant_idx]`.
  - On transfer, latch `req_a` slice `grant_idx` into the operand register, drop ack, and go to ISSUE.
  - If the requester drops stb before the transfer (protocol violation), hold ack and wait. There is no timeout.
- **ISSUE:**
  - Drive `conv_a` from the operand register and assert `conv_a_stb`.
  - On transfer, drop stb and go to COLLECT.
- **COLLECT:**
  - Assert `conv_z_ack`.
  - On transfer, latch `conv_z` into the result register, drop ack, and go to DELIVER.
- **DELIVER:**
  - Drive `req_z` from the result register and assert `req_z_stb[grant_idx]`.
  - On transfer: drop stb, set `last` to `grant_idx`, increment `conv_count` (wrapping), and go to IDLE.
- **Arbitration timing:**
  - New requests arriving during a conversion are not observed until IDLE.
  - A grant is never pre-empted.
  - `req_a_ack` bits other than `grant_idx` stay 0 throughout.
- **Data path:** data is passed through unmodified. The block performs no arithmetic on operands or results.
- **Reset values:**
  - state = IDLE.
  - All `req_a_ack`, `req_z_stb`, `conv_a_stb`, `conv_z_ack` = 0.
  - `busy` = 0, `conv_count` = 0, `grant_idx` = 0.
  - `last` = N_REQ−1, so requester 0 wins first.
- **Reset mid-operation:**
  - Any in-flight conversion is abandoned and no result is delivered.
  - The converter shares `rst`, so it is cleared in the same cycle.
  - Operand and result registers need not be cleared.
- **`req_z` when idle:** holds its last value; it is meaningful only while a `req_z_stb` bit is high.

## Timing

- **Request to `req_a_ack`:** a `req_a_stb` first seen in IDLE at edge k gives GRANT at k+1 and `req_a_ack` high in the cycle after edge k+2.
- **Arbiter overhead per conversion:**
  - Each of GRANT, ISSUE, COLLECT and DELIVER takes at least 2 cycles: one cycle to raise the registered stb/ack, one for the transfer edge.
  - IDLE takes 1 cycle.
  - Total is 9 cycles minimum, plus converter latency, plus any ack or stb delay from the far side.
- **Back-to-back:** no IDLE bypass. There is always at least one IDLE cycle between a DELIVER transfer and the next grant.
- **`busy`:** registered; rises the cycle after leaving IDLE and falls the cycle after returning to IDLE.
- **`conv_count`:** updates on the DELIVER transfer edge and is visible the next cycle.

## Test plan

- **Single request:** requester 0 sends `64'd1` → `req_z_stb[0]` with `req_z = 64'h3FF0000000000000`; `conv_count` = 1; only bit 0 of `req_a_ack` / `req_z_stb` ever high.
- **Sign and zero:** requester 3 sends `64'hFFFFFFFFFFFFFFFF` (−1), then `64'd0`.
  - Results: `64'hBFF0000000000000`, then `64'h0000000000000000`, both on `req_z_stb[3]`.
  - `grant_idx` = 3 for both.
- **Fairness:** all four requesters hold stb with values 1, 2, 3, 4 from reset.
  - Grants in order 0, 1, 2, 3.
  - Results `3FF0…`, `4000…`, `4008…`, `4010…` (each followed by zeros).
  - Requesters 0 and 2 re-request continuously → alternate 0, 2, 0, 2.
- **Back-pressure:** hold `req_z_ack[1]` low for 5 cycles in DELIVER.
  - `req_z_stb[1]` and `req_z` stay stable.
  - No new grant is issued, `busy` = 1, and `conv_count` does not change until the ack.
- **Converter stall:** delay `conv_a_ack` by 3 cycles and `conv_z_stb` by 10 cycles → `conv_a_stb` and `conv_z_ack` are held without glitches and the result is delivered correctly.
- **Reset mid-COLLECT:**
  - Assert `rst` for 1 cycle.
  - Next cycle: all strobes and acks are 0, `busy` = 0, `conv_count` = 0, and no stale `req_z_stb` appears.
  - A subsequent request from requester 2 alone is granted and converted correctly.
